// File: rtl/mmss_timer_ctrl_if.sv
// rtl/mmss_timer_ctrl_if.sv - control, switch and display bundle of the MM:SS timer
interface mmss_timer_ctrl_if #(
    parameter int MIN_DIGITS = 2
);
    localparam int W = 4 * (MIN_DIGITS + 2);

    logic         set;
    logic         start_stop;
    logic         count_up;
    logic         auto_reload;
    logic [3:0]   sw_tens;
    logic [3:0]   sw_ones;
    logic [W-1:0] digits;
    logic [2:0]   state_o;
    logic         tick;
    logic         done;
    logic         alarm;

    modport master (
        output set, start_stop, count_up, auto_reload, sw_tens, sw_ones,
        input  digits, state_o, tick, done, alarm
    );

    modport slave (
        input  set, start_stop, count_up, auto_reload, sw_tens, sw_ones,
        output digits, state_o, tick, done, alarm
    );
endinterface

// File: rtl/mmss_timer_ctrl.sv
// rtl/mmss_timer_ctrl.sv - BCD MM:SS timer: tick divider, set/run FSM, cascaded up/down count
module mmss_timer_ctrl #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int MIN_DIGITS = 2,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic              clk,
    input  logic              reset,
    mmss_timer_ctrl_if.slave  bus
);
    localparam int ND    = MIN_DIGITS + 2;
    localparam int W     = 4 * ND;
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int BLK_W = $clog2(BLINK_DIV + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SET_SEC = 3'd1;
    localparam logic [2:0] SET_MIN = 3'd2;
    localparam logic [2:0] STOPPED = 3'd3;
    localparam logic [2:0] RUN     = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [W-1:0]     digits_q, digits_d;
    logic [W-1:0]     preset_q, preset_d;
    logic             mode_q, mode_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BLK_W-1:0] blink_q, blink_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             alarm_q, alarm_d;

    logic [W-1:0]     sec_val, min_val, step_val, reload_val;
    logic             cur_term, step_term;

    function automatic logic [3:0] sat(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // One BCD step; the seconds-tens digit rolls at 5, every other digit at 9.
    function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic up);
        logic [W-1:0] r;
        logic         c;
        logic [3:0]   n;
        logic [3:0]   lim;
        r = v;
        c = 1'b1;
        for (int i = 0; i < ND; i++) begin
            n   = v[4*i +: 4];
            lim = (i == 1) ? 4'd5 : 4'd9;
            if (c) begin
                if (up) begin
                    if (n >= lim) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = n + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (n == 4'd0) begin
                        r[4*i +: 4] = lim;
                    end else begin
                        r[4*i +: 4] = n - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        preset_d = preset_q;
        mode_d   = mode_q;
        div_d    = div_q;
        blink_d  = blink_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;
        alarm_d  = 1'b0;

        sec_val      = digits_q;
        sec_val[7:4] = sat(bus.sw_tens, 4'd5);
        sec_val[3:0] = sat(bus.sw_ones, 4'd9);

        min_val = digits_q;
        for (int i = 2; i < ND; i++) begin
            if (i == 2)      min_val[4*i +: 4] = sat(bus.sw_ones, 4'd9);
            else if (i == 3) min_val[4*i +: 4] = sat(bus.sw_tens, 4'd9);
            else             min_val[4*i +: 4] = 4'd0;
        end

        step_val   = bcd_step(digits_q, mode_q);
        reload_val = mode_q ? '0 : preset_q;
        cur_term   = mode_q ? (digits_q == preset_q) : (digits_q == '0);
        step_term  = mode_q ? (step_val == preset_q) : (step_val == '0);

        case (state_q)
            IDLE: begin
                if (bus.set) state_d = SET_SEC;
            end
            SET_SEC: begin
                digits_d = sec_val;
                if (bus.set) state_d = SET_MIN;
            end
            SET_MIN: begin
                digits_d = min_val;
                if (bus.set) begin
                    preset_d = min_val;
                    mode_d   = bus.count_up;
                    if (bus.count_up) digits_d = '0;
                    state_d  = STOPPED;
                end
            end
            STOPPED: begin
                if (bus.start_stop) begin
                    div_d = '0;
                    if (cur_term) begin
                        done_d  = 1'b1;
                        alarm_d = 1'b1;
                        blink_d = '0;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else if (bus.set) begin
                    state_d = SET_SEC;
                end
            end
            RUN: begin
                // A pause landing on a tick edge wins and the step is dropped.
                if (bus.start_stop) begin
                    state_d = STOPPED;
                end else if (div_q == DIV_LAST) begin
                    div_d    = '0;
                    tick_d   = 1'b1;
                    digits_d = step_val;
                    if (step_term) begin
                        done_d = 1'b1;
                        if (bus.auto_reload) begin
                            digits_d = reload_val;
                        end else begin
                            alarm_d = 1'b1;
                            blink_d = '0;
                            state_d = DONE;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.set || bus.start_stop) begin
                    mode_d   = bus.count_up;
                    digits_d = bus.count_up ? '0 : preset_q;
                    state_d  = STOPPED;
                end else if (blink_q == BLK_LAST) begin
                    blink_d = '0;
                    alarm_d = ~alarm_q;
                end else begin
                    blink_d = blink_q + 1'b1;
                    alarm_d = alarm_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            digits_q <= '0;
            preset_q <= '0;
            mode_q   <= 1'b0;
            div_q    <= '0;
            blink_q  <= '0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            preset_q <= preset_d;
            mode_q   <= mode_d;
            div_q    <= div_d;
            blink_q  <= blink_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
            alarm_q  <= alarm_d;
        end
    end

    assign bus.digits  = digits_q;
    assign bus.state_o = state_q;
    assign bus.tick    = tick_q;
    assign bus.done    = done_q;
    assign bus.alarm   = alarm_q;
endmodule

// File: tb/tb_mmss_timer_ctrl.sv
// tb/tb_mmss_timer_ctrl.sv - directed bench with an elapsed-seconds reference model
module tb_mmss_timer_ctrl;
    localparam int TICK  = 4;
    localparam int BLINK = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mmss_timer_ctrl_if #(.MIN_DIGITS(2)) bus();

    mmss_timer_ctrl #(
        .TICK_DIV  (TICK),
        .MIN_DIGITS(2),
        .BLINK_DIV (BLINK)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    // Reference model: the count is held as whole seconds, not as BCD digits.
    int m_state  = 0;
    int m_secs   = 0;
    int m_preset = 0;
    int m_div    = 0;
    int m_entry  = 0;
    int cyc      = 0;
    bit m_up     = 1'b0;
    bit m_tick   = 1'b0;
    bit m_done   = 1'b0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [15:0] bcd16(input int t);
        int s = t % 60;
        int m = t / 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic bit at_term(input int s);
        return m_up ? (s == m_preset) : (s == 0);
    endfunction

    function automatic bit exp_alarm();
        if (m_state != 5) return 1'b0;
        return (((cyc - m_entry) / BLINK) % 2) == 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        m_tick = 1'b0;
        m_done = 1'b0;
        if (reset) begin
            m_state = 0; m_secs = 0; m_preset = 0; m_up = 1'b0; m_div = 0;
        end else begin
            case (m_state)
                0: if (bus.set) m_state = 1;
                1: begin
                    m_secs = (m_secs / 60) * 60 + 10 * imin(int'(bus.sw_tens), 5)
                             + imin(int'(bus.sw_ones), 9);
                    if (bus.set) m_state = 2;
                end
                2: begin
                    m_secs = 60 * (10 * imin(int'(bus.sw_tens), 9) + imin(int'(bus.sw_ones), 9))
                             + m_secs % 60;
                    if (bus.set) begin
                        m_preset = m_secs;
                        m_up     = bus.count_up;
                        if (m_up) m_secs = 0;
                        m_state  = 3;
                    end
                end
                3: begin
                    if (bus.start_stop) begin
                        m_div = 0;
                        if (at_term(m_secs)) begin
                            m_done = 1'b1; m_state = 5; m_entry = cyc;
                        end else begin
                            m_state = 4;
                        end
                    end else if (bus.set) begin
                        m_state = 1;
                    end
                end
                4: begin
                    if (bus.start_stop) begin
                        m_state = 3;
                    end else if (m_div == TICK - 1) begin
                        m_div  = 0;
                        m_tick = 1'b1;
                        m_secs = m_up ? m_secs + 1 : m_secs - 1;
                        if (at_term(m_secs)) begin
                            m_done = 1'b1;
                            if (bus.auto_reload) m_secs = m_up ? 0 : m_preset;
                            else begin m_state = 5; m_entry = cyc; end
                        end
                    end else begin
                        m_div++;
                    end
                end
                5: begin
                    if (bus.set || bus.start_stop) begin
                        m_up    = bus.count_up;
                        m_secs  = m_up ? 0 : m_preset;
                        m_state = 3;
                    end
                end
                default: m_state = 0;
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en)
            check("model", {10'd0, bus.state_o, bus.digits, bus.tick, bus.done, bus.alarm},
                  {10'd0, 3'(m_state), bcd16(m_secs), m_tick, m_done, exp_alarm()});
    end

    task automatic pulse(input logic s, input logic ss);
        bus.set        = s;
        bus.start_stop = ss;
        @(negedge clk);
        bus.set        = 1'b0;
        bus.start_stop = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ticks(input int n);
        int seen   = 0;
        int budget = n * TICK * 2 + 10;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (bus.tick) seen++;
        end
        if (seen < n) check("tick_timeout", seen, n);
    endtask

    logic [5:0] pat;

    initial begin
        bus.set = 0; bus.start_stop = 0; bus.count_up = 0; bus.auto_reload = 0;
        bus.sw_tens = 0; bus.sw_ones = 0;
        pat = 6'b100011;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        cmp_en = 1'b1;
        check("rst_state", bus.state_o, 3'd0);
        check("rst_digits", bus.digits, 16'h0000);
        check("rst_flags", {bus.tick, bus.done, bus.alarm}, 3'b000);

        // IDLE ignores start_stop; set wins when both arrive together
        pulse(0, 1);
        check("idle_ss_ignored", bus.state_o, 3'd0);
        pulse(1, 1);
        check("idle_set_wins", bus.state_o, 3'd1);

        // switch saturation while setting seconds
        bus.sw_tens = 4'd7; bus.sw_ones = 4'd12;
        step(1);
        check("sat_59", bus.digits[7:0], 8'h59);

        // preset 01:02 counting down
        bus.sw_tens = 4'd0; bus.sw_ones = 4'd2;
        pulse(1, 0);
        bus.sw_ones = 4'd1; bus.count_up = 1'b0;
        pulse(1, 0);
        check("preset_0102", {bus.state_o, bus.digits}, {3'd3, 16'h0102});
        pulse(0, 1);
        wait_ticks(3);
        check("down_0059", bus.digits, 16'h0059);
        wait_ticks(59);
        check("expire_done", {bus.state_o, bus.done, bus.alarm}, {3'd5, 1'b1, 1'b1});
        check("expire_digits", bus.digits, 16'h0000);
        for (int k = 0; k < 6; k++) begin
            step(1);
            check("alarm_blink", bus.alarm, pat[k]);
            if (k == 0) check("done_one_cycle", bus.done, 1'b0);
        end
        pulse(1, 0);
        check("rearm_down", {bus.state_o, bus.digits, bus.alarm}, {3'd3, 16'h0102, 1'b0});

        // pause on the tick edge discards the step; resume ticks 4 cycles later
        pulse(0, 1);
        step(3);
        pulse(0, 1);
        check("pause_on_tick", {bus.state_o, bus.digits, bus.tick}, {3'd3, 16'h0102, 1'b0});
        pulse(0, 1);
        step(3);
        check("resume_no_tick", {bus.tick, bus.digits}, {1'b0, 16'h0102});
        step(1);
        check("resume_tick", {bus.tick, bus.digits}, {1'b1, 16'h0101});
        pulse(0, 1);

        // count-up to 00:03 with auto-reload, then without
        bus.sw_tens = 4'd0; bus.sw_ones = 4'd3;
        pulse(1, 0);
        pulse(1, 0);
        bus.sw_ones = 4'd0; bus.count_up = 1'b1;
        pulse(1, 0);
        check("up_preset", {bus.state_o, bus.digits}, {3'd3, 16'h0000});
        bus.auto_reload = 1'b1;
        pulse(1, 1);
        check("stopped_ss_wins", bus.state_o, 3'd4);
        wait_ticks(1);
        check("up_1", bus.digits, 16'h0001);
        wait_ticks(1);
        check("up_2", bus.digits, 16'h0002);
        wait_ticks(1);
        check("reload", {bus.state_o, bus.digits, bus.done}, {3'd4, 16'h0000, 1'b1});
        bus.auto_reload = 1'b0; bus.count_up = 1'b0;
        wait_ticks(3);
        check("up_done", {bus.state_o, bus.digits, bus.done}, {3'd5, 16'h0003, 1'b1});

        // zero preset down: start expires at once
        pulse(1, 0);
        check("rearm_to_down", {bus.state_o, bus.digits}, {3'd3, 16'h0003});
        pulse(1, 0);
        pulse(1, 0);
        pulse(1, 0);
        check("zero_preset", {bus.state_o, bus.digits}, {3'd3, 16'h0000});
        pulse(0, 1);
        check("zero_expire", {bus.state_o, bus.done, bus.alarm}, {3'd5, 1'b1, 1'b1});
        pulse(1, 0);
        check("zero_rearm", {bus.state_o, bus.alarm, bus.done}, {3'd3, 1'b0, 1'b0});

        // reset in the middle of a run
        bus.sw_ones = 4'd5;
        pulse(1, 0);
        pulse(1, 0);
        bus.sw_ones = 4'd0;
        pulse(1, 0);
        pulse(0, 1);
        wait_ticks(1);
        check("run_0004", bus.digits, 16'h0004);
        pulse(1, 0);
        check("run_set_ignored", bus.state_o, 3'd4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrun_reset", {bus.state_o, bus.digits, bus.tick, bus.done, bus.alarm},
              {3'd0, 16'h0000, 3'b000});

        step(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
